// File: rtl/cpu_job_sequencer_if.sv
// Bundles the host control, load/dump streams and the cpu external memory ports
// seen by cpu_job_sequencer.
interface cpu_job_sequencer_if #(
    parameter int unsigned IMEM_AW = 9,
    parameter int unsigned DMEM_AW = 10,
    parameter int unsigned RUN_W   = 32
);
    logic               start;
    logic [IMEM_AW:0]   imem_words;
    logic [DMEM_AW:0]   dmem_words;
    logic [RUN_W-1:0]   run_cycles;
    logic [DMEM_AW:0]   dump_words;

    logic               ld_valid;
    logic               ld_ready;
    logic [63:0]        ld_data;

    logic               dump_valid;
    logic               dump_ready;
    logic [63:0]        dump_data;

    logic               cpu_enable;
    logic [63:0]        addr_ext;
    logic               wen_ext;
    logic               ren_ext;
    logic [31:0]        wdata_ext;
    logic [63:0]        addr_ext_2;
    logic               wen_ext_2;
    logic               ren_ext_2;
    logic [63:0]        wdata_ext_2;
    logic [63:0]        rdata_ext_2;

    logic               busy;
    logic               done;

    // Host / environment side.
    modport master (
        output start, imem_words, dmem_words, run_cycles, dump_words,
        output ld_valid, ld_data, dump_ready, rdata_ext_2,
        input  ld_ready, dump_valid, dump_data, cpu_enable,
        input  addr_ext, wen_ext, ren_ext, wdata_ext,
        input  addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
        input  busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, imem_words, dmem_words, run_cycles, dump_words,
        input  ld_valid, ld_data, dump_ready, rdata_ext_2,
        output ld_ready, dump_valid, dump_data, cpu_enable,
        output addr_ext, wen_ext, ren_ext, wdata_ext,
        output addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
        output busy, done
    );
endinterface

// File: rtl/cpu_job_sequencer.sv
// Sequences one job on the core: load imem, load dmem, settle, run for a fixed
// cycle count, then stream a window of dmem back to the host.
module cpu_job_sequencer #(
    parameter int unsigned IMEM_AW = 9,
    parameter int unsigned DMEM_AW = 10,
    parameter int unsigned RUN_W   = 32
) (
    input  logic                clk,
    input  logic                arst_n,
    cpu_job_sequencer_if.slave  bus
);
    // k must hold the largest count itself so the last-word compare never wraps.
    localparam int unsigned K_W  = ((IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW) + 1;
    localparam int unsigned IW_W = IMEM_AW + 1;
    localparam int unsigned DW_W = DMEM_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_D, S_SETTLE, S_RUN, S_DUMP_REQ, S_DUMP_CAP, S_DUMP_OUT
    } state_e;

    state_e            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [IW_W-1:0]   imem_words_q, imem_words_d;
    logic [DW_W-1:0]   dmem_words_q, dmem_words_d;
    logic [RUN_W-1:0]  run_cycles_q, run_cycles_d;
    logic [DW_W-1:0]   dump_words_q, dump_words_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              ld_ready_q, ld_ready_d;
    logic              wen_q, wen_d;
    logic [63:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wen2_q, wen2_d;
    logic              ren2_q, ren2_d;
    logic [63:0]       addr2_q, addr2_d;
    logic [63:0]       wdata2_q, wdata2_d;
    logic [63:0]       dump_data_q, dump_data_d;
    logic              dump_valid_q, dump_valid_d;
    logic              cpu_enable_q, cpu_enable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [K_W-1:0]    k_inc;
    logic              ld_fire;
    logic              dump_fire;

    assign k_inc     = k_q + K_W'(1);
    assign ld_fire   = bus.ld_valid && ld_ready_q;
    assign dump_fire = bus.dump_ready && dump_valid_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            imem_words_q <= '0;
            dmem_words_q <= '0;
            run_cycles_q <= '0;
            dump_words_q <= '0;
            run_cnt_q    <= '0;
            ld_ready_q   <= 1'b0;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wen2_q       <= 1'b0;
            ren2_q       <= 1'b0;
            addr2_q      <= '0;
            wdata2_q     <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            cpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            imem_words_q <= imem_words_d;
            dmem_words_q <= dmem_words_d;
            run_cycles_q <= run_cycles_d;
            dump_words_q <= dump_words_d;
            run_cnt_q    <= run_cnt_d;
            ld_ready_q   <= ld_ready_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wen2_q       <= wen2_d;
            ren2_q       <= ren2_d;
            addr2_q      <= addr2_d;
            wdata2_q     <= wdata2_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            cpu_enable_q <= cpu_enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        imem_words_d = imem_words_q;
        dmem_words_d = dmem_words_q;
        run_cycles_d = run_cycles_q;
        dump_words_d = dump_words_q;
        run_cnt_d    = run_cnt_q;
        wen_d        = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wen2_d       = 1'b0;
        addr2_d      = addr2_q;
        wdata2_d     = wdata2_q;
        dump_data_d  = dump_data_q;
        done_d       = done_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    imem_words_d = bus.imem_words;
                    dmem_words_d = bus.dmem_words;
                    run_cycles_d = bus.run_cycles;
                    dump_words_d = bus.dump_words;
                    k_d          = '0;
                    done_d       = 1'b0;
                    if (bus.imem_words != '0) begin
                        state_d = S_LOAD_I;
                    end else if (bus.dmem_words != '0) begin
                        state_d = S_LOAD_D;
                    end else if (bus.run_cycles != '0) begin
                        state_d   = S_RUN;
                        run_cnt_d = bus.run_cycles;
                    end else if (bus.dump_words != '0) begin
                        state_d = S_DUMP_REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD_I: begin
                if (ld_fire) begin
                    wen_d   = 1'b1;
                    addr_d  = 64'(k_q) << 2;
                    wdata_d = bus.ld_data[31:0];
                    if (k_inc == K_W'(imem_words_q)) begin
                        k_d     = '0;
                        state_d = (dmem_words_q != '0) ? S_LOAD_D : S_SETTLE;
                    end else begin
                        k_d = k_inc;
                    end
                end
            end
            S_LOAD_D: begin
                if (ld_fire) begin
                    wen2_d   = 1'b1;
                    addr2_d  = 64'(k_q) << 3;
                    wdata2_d = bus.ld_data;
                    if (k_inc == K_W'(dmem_words_q)) begin
                        k_d     = '0;
                        state_d = S_SETTLE;
                    end else begin
                        k_d = k_inc;
                    end
                end
            end
            // One idle cycle lets the last write pulse land before the core runs.
            S_SETTLE: begin
                if (run_cycles_q != '0) begin
                    state_d   = S_RUN;
                    run_cnt_d = run_cycles_q;
                end else if (dump_words_q != '0) begin
                    state_d = S_DUMP_REQ;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q - RUN_W'(1);
                if (run_cnt_q == RUN_W'(1)) begin
                    if (dump_words_q != '0) begin
                        state_d = S_DUMP_REQ;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DUMP_REQ: state_d = S_DUMP_CAP;
            S_DUMP_CAP: begin
                dump_data_d = bus.rdata_ext_2;
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (dump_fire) begin
                    if (k_inc == K_W'(dump_words_q)) begin
                        k_d     = '0;
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        k_d     = k_inc;
                        state_d = S_DUMP_REQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Level outputs are registered copies of the next state.
        ld_ready_d   = (state_d == S_LOAD_I) || (state_d == S_LOAD_D);
        cpu_enable_d = (state_d == S_RUN);
        ren2_d       = (state_d == S_DUMP_REQ);
        dump_valid_d = (state_d == S_DUMP_OUT);
        busy_d       = (state_d != S_IDLE);
        if (ren2_d) begin
            addr2_d = 64'(k_d) << 3;
        end
    end

    assign bus.ld_ready    = ld_ready_q;
    assign bus.dump_valid  = dump_valid_q;
    assign bus.dump_data   = dump_data_q;
    assign bus.cpu_enable  = cpu_enable_q;
    assign bus.addr_ext    = addr_q;
    assign bus.wen_ext     = wen_q;
    assign bus.ren_ext     = 1'b0;
    assign bus.wdata_ext   = wdata_q;
    assign bus.addr_ext_2  = addr2_q;
    assign bus.wen_ext_2   = wen2_q;
    assign bus.ren_ext_2   = ren2_q;
    assign bus.wdata_ext_2 = wdata2_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_cpu_job_sequencer.sv
// Directed bench for cpu_job_sequencer with behavioural imem/dmem models.
module tb_cpu_job_sequencer;
    localparam int unsigned IMEM_AW = 9;
    localparam int unsigned DMEM_AW = 10;
    localparam int unsigned RUN_W   = 32;
    localparam int unsigned IW_W    = IMEM_AW + 1;
    localparam int unsigned DW_W    = DMEM_AW + 1;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    cpu_job_sequencer_if #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .RUN_W(RUN_W)) bus ();

    cpu_job_sequencer #(.IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .RUN_W(RUN_W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] imem [0:(1 << IMEM_AW) - 1];
    logic [63:0] dmem [0:(1 << DMEM_AW) - 1];
    int cyc         = 0;
    int viol        = 0;
    int wen2_pulses = 0;
    int activity    = 0;

    // Memory models: synchronous write, one-cycle registered read.
    always @(posedge clk) begin
        if (bus.wen_ext)   imem[bus.addr_ext[IMEM_AW+1:2]]   <= bus.wdata_ext;
        if (bus.wen_ext_2) dmem[bus.addr_ext_2[DMEM_AW+2:3]] <= bus.wdata_ext_2;
        if (bus.ren_ext_2) bus.rdata_ext_2 <= dmem[bus.addr_ext_2[DMEM_AW+2:3]];
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if ((bus.wen_ext && bus.ren_ext) || (bus.wen_ext_2 && bus.ren_ext_2) ||
            (bus.cpu_enable && (bus.wen_ext || bus.ren_ext || bus.wen_ext_2 || bus.ren_ext_2)) ||
            (bus.ld_ready && !bus.busy) || (bus.dump_valid && !bus.busy))
            viol = viol + 1;
        if (bus.wen_ext_2) wen2_pulses = wen2_pulses + 1;
        if (bus.wen_ext || bus.wen_ext_2 || bus.ren_ext_2 || bus.ld_ready ||
            bus.dump_valid || bus.cpu_enable || bus.busy)
            activity = activity + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int im, input int dm, input int rc, input int dw);
        bus.imem_words = IW_W'(im);
        bus.dmem_words = DW_W'(dm);
        bus.run_cycles = RUN_W'(rc);
        bus.dump_words = DW_W'(dw);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !bus.done; i++) tick();
        check(tag, 64'(bus.done), 64'd1);
    endtask

    initial begin
        logic [31:0] iw [0:2];
        logic [63:0] dv [0:3];
        int base, n, got, ren_cyc;
        int acc [0:3];

        iw[0] = 32'h1111_0013; iw[1] = 32'h2222_0093; iw[2] = 32'h3333_0113;
        dv[0] = 64'hA; dv[1] = 64'hB; dv[2] = 64'hC; dv[3] = 64'hD;
        ren_cyc = 0;
        bus.start = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.dump_ready = 1'b0;
        bus.imem_words = '0; bus.dmem_words = '0; bus.run_cycles = '0; bus.dump_words = '0;
        arst_n = 1'b0;

        // Reset state
        #12;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_ports", {bus.addr_ext[31:0], bus.wdata_ext} | bus.addr_ext_2 | bus.wdata_ext_2 |
              bus.dump_data, 64'd0);
        check("rst_en", 64'({bus.cpu_enable, bus.wen_ext, bus.ren_ext, bus.wen_ext_2,
              bus.ren_ext_2, bus.ld_ready, bus.dump_valid}), 64'd0);
        #1 arst_n = 1'b1;
        tick();

        // All counts zero: done next cycle, no port activity
        base = activity;
        start_job(0, 0, 0, 0);
        check("zero_done", 64'(bus.done), 64'd1);
        check("zero_busy", 64'(bus.busy), 64'd0);
        tick();
        check("zero_activity", 64'(activity - base), 64'd0);

        // imem load of 3 back-to-back words
        start_job(3, 0, 0, 0);
        check("li_done_clr", 64'(bus.done), 64'd0);
        check("li_busy", 64'(bus.busy), 64'd1);
        check("li_ready", 64'(bus.ld_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = {32'hDEAD_BEEF, iw[i]};
            tick();
            check($sformatf("li_wen%0d", i), 64'(bus.wen_ext), 64'd1);
            check($sformatf("li_addr%0d", i), bus.addr_ext, 64'(4 * i));
            check($sformatf("li_wdata%0d", i), 64'(bus.wdata_ext), 64'(iw[i]));
        end
        bus.ld_valid = 1'b0;
        check("li_settle_ready", 64'(bus.ld_ready), 64'd0);
        check("li_settle_done", 64'(bus.done), 64'd0);
        tick();
        check("li_wen_off", 64'(bus.wen_ext), 64'd0);
        check("li_done", 64'(bus.done), 64'd1);
        check("li_busy_off", 64'(bus.busy), 64'd0);
        check("li_mem1", 64'(imem[1]), 64'(iw[1]));

        // dmem load with ld_valid toggling
        base = wen2_pulses;
        start_job(0, 2, 0, 0);
        bus.ld_valid = 1'b1; bus.ld_data = 64'h0123_4567_89AB_CDEF;
        tick();
        check("ld_w0", 64'(bus.wen_ext_2), 64'd1);
        check("ld_a0", bus.addr_ext_2, 64'd0);
        check("ld_d0", bus.wdata_ext_2, 64'h0123_4567_89AB_CDEF);
        bus.ld_valid = 1'b0;
        tick();
        check("ld_gap", 64'(bus.wen_ext_2), 64'd0);
        bus.ld_valid = 1'b1; bus.ld_data = 64'hFEDC_BA98_7654_3210;
        tick();
        check("ld_w1", 64'(bus.wen_ext_2), 64'd1);
        check("ld_a1", bus.addr_ext_2, 64'd8);
        check("ld_d1", bus.wdata_ext_2, 64'hFEDC_BA98_7654_3210);
        bus.ld_valid = 1'b0;
        wait_done("ld_done", 10);
        check("ld_pulses", 64'(wen2_pulses - base), 64'd2);

        // Run 17 cycles after a one-word imem load
        start_job(1, 0, 17, 0);
        bus.ld_valid = 1'b1; bus.ld_data = 64'h13;
        tick();
        bus.ld_valid = 1'b0;
        check("run_settle_en", 64'(bus.cpu_enable), 64'd0);
        check("run_settle_wen", 64'(bus.wen_ext), 64'd1);
        n = 0;
        for (int i = 0; i < 40 && !bus.done; i++) begin
            tick();
            if (bus.cpu_enable) n = n + 1;
        end
        check("run_len", 64'(n), 64'd17);
        check("run_done", 64'(bus.done), 64'd1);

        // start pulsed during RUN is ignored
        start_job(0, 0, 5, 0);
        n = bus.cpu_enable ? 1 : 0;
        tick();
        if (bus.cpu_enable) n = n + 1;
        bus.imem_words = IW_W'(7);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (bus.cpu_enable) n = n + 1;
        check("ign_ready", 64'(bus.ld_ready), 64'd0);
        for (int i = 0; i < 20 && !bus.done; i++) begin
            tick();
            if (bus.cpu_enable) n = n + 1;
        end
        check("ign_run_len", 64'(n), 64'd5);
        tick();
        check("ign_idle", 64'({bus.busy, bus.ld_ready}), 64'd0);

        // Load dmem[0..3] then dump 4 words with a stall on word 2
        start_job(0, 4, 0, 4);
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1; bus.ld_data = dv[i];
            tick();
        end
        bus.ld_valid = 1'b0;
        bus.dump_ready = 1'b1;
        got = 0;
        for (int g = 0; g < 80 && got < 4; g++) begin
            if (bus.ren_ext_2) ren_cyc = cyc;
            if (bus.dump_valid) begin
                if (got == 0) check("dump_lat", 64'(cyc - ren_cyc), 64'd2);
                check($sformatf("dump_w%0d", got), bus.dump_data, dv[got]);
                if (got == 2) begin
                    bus.dump_ready = 1'b0;
                    repeat (5) tick();
                    check("dump_stall_v", 64'(bus.dump_valid), 64'd1);
                    check("dump_stall_d", bus.dump_data, dv[2]);
                    bus.dump_ready = 1'b1;
                end
                acc[got] = cyc;
                got = got + 1;
            end
            tick();
        end
        bus.dump_ready = 1'b0;
        check("dump_count", 64'(got), 64'd4);
        check("dump_done", 64'(bus.done), 64'd1);
        check("dump_rate01", 64'(acc[1] - acc[0]), 64'd3);
        check("dump_rate23", 64'(acc[3] - acc[2]), 64'd3);

        // Async reset mid-LOAD_D, then a fresh job restarts at address 0
        start_job(0, 3, 0, 0);
        bus.ld_valid = 1'b1; bus.ld_data = 64'h111;
        tick();
        bus.ld_data = 64'h222;
        #2 arst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_en", 64'({bus.wen_ext_2, bus.ld_ready, bus.done}), 64'd0);
        check("arst_addr", bus.addr_ext_2 | bus.wdata_ext_2, 64'd0);
        bus.ld_valid = 1'b0;
        tick();
        #2 arst_n = 1'b1;
        tick();
        start_job(0, 2, 0, 0);
        bus.ld_valid = 1'b1; bus.ld_data = 64'h333;
        tick();
        check("re_addr", bus.addr_ext_2, 64'd0);
        check("re_data", bus.wdata_ext_2, 64'h333);
        bus.ld_data = 64'h444;
        tick();
        bus.ld_valid = 1'b0;
        check("re_addr1", bus.addr_ext_2, 64'd8);
        wait_done("re_done", 10);

        check("invariants", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
